// File: rtl/sobel_stream.sv
// sobel_stream: streaming 3x3 Sobel edge detector with line buffers and magnitude/threshold output.
//   clk_i         rising-edge clock
//   nreset_i      asynchronous active-low reset
//   start_i       frame start pulse, restarts counters from any state
//   px_valid_i    input pixel strobe (no backpressure)
//   px_i          grayscale input pixel, raster order
//   mode_i        0 = saturated |Gx|+|Gy|, 1 = binary threshold
//   threshold_i   threshold used in mode 1
//   px_valid_o    one-cycle pulse per interior-pixel result
//   px_o          Sobel result, held between pulses
//   frame_done_o  pulse with the last result of a frame
//   busy_o        high while a frame is being received
module sobel_stream #(
   parameter int PIXEL_WIDTH = 8,
   parameter int IMG_WIDTH   = 8,
   parameter int IMG_HEIGHT  = 8
) (
   input  logic                   clk_i,
   input  logic                   nreset_i,
   input  logic                   start_i,
   input  logic                   px_valid_i,
   input  logic [PIXEL_WIDTH-1:0] px_i,
   input  logic                   mode_i,
   input  logic [PIXEL_WIDTH-1:0] threshold_i,
   output logic                   px_valid_o,
   output logic [PIXEL_WIDTH-1:0] px_o,
   output logic                   frame_done_o,
   output logic                   busy_o
);
   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam int AW = PIXEL_WIDTH + 4;
   typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;
   state_t state, state_n, st_eff;
   logic [CW-1:0] col, col_e, col_n;
   logic [RW-1:0] row, row_e, row_n;
   logic acc, last_col, last_row, emit;
   logic [PIXEL_WIDTH-1:0] lb1 [IMG_WIDTH];
   logic [PIXEL_WIDTH-1:0] lb2 [IMG_WIDTH];
   logic [PIXEL_WIDTH-1:0] w [9];
   logic [PIXEL_WIDTH-1:0] nw [9];
   logic signed [AW-1:0] gx, gy, ax, ay;
   logic [AW-1:0] mag;
   logic [PIXEL_WIDTH-1:0] sat, res;

   function automatic logic signed [AW-1:0] ext(input logic [PIXEL_WIDTH-1:0] p);
      return signed'({4'b0000, p});
   endfunction

   // start_i makes the same-cycle pixel (0,0) of a fresh frame
   always_comb begin
      st_eff   = start_i ? FILL : state;
      col_e    = start_i ? '0 : col;
      row_e    = start_i ? '0 : row;
      acc      = px_valid_i && (st_eff != IDLE);
      last_col = col_e == CW'(IMG_WIDTH - 1);
      last_row = row_e == RW'(IMG_HEIGHT - 1);
      emit     = acc && row_e >= RW'(2) && col_e >= CW'(2);
      col_n    = acc ? (last_col ? '0 : col_e + 1'b1) : col_e;
      row_n    = (acc && last_col) ? (last_row ? '0 : row_e + 1'b1) : row_e;
      state_n  = st_eff;
      if (acc && last_col && st_eff == FILL && row_e == RW'(1))
         state_n = STREAM;
      if (acc && last_col && last_row && st_eff == STREAM)
         state_n = IDLE;
   end

   // window after this beat's shift: each row moves left, new column on the right
   always_comb begin
      nw[0] = w[1];
      nw[1] = w[2];
      nw[2] = lb2[col_e];
      nw[3] = w[4];
      nw[4] = w[5];
      nw[5] = lb1[col_e];
      nw[6] = w[7];
      nw[7] = w[8];
      nw[8] = px_i;
   end

   // the result is formed from the post-shift window so it registers on the acceptance edge
   always_comb begin
      gx  = (ext(nw[2]) + ext(nw[5]) + ext(nw[5]) + ext(nw[8]))
          - (ext(nw[0]) + ext(nw[3]) + ext(nw[3]) + ext(nw[6]));
      gy  = (ext(nw[6]) + ext(nw[7]) + ext(nw[7]) + ext(nw[8]))
          - (ext(nw[0]) + ext(nw[1]) + ext(nw[1]) + ext(nw[2]));
      ax  = gx[AW-1] ? -gx : gx;
      ay  = gy[AW-1] ? -gy : gy;
      mag = unsigned'(ax) + unsigned'(ay);
      sat = (mag > AW'({PIXEL_WIDTH{1'b1}})) ? '1 : mag[PIXEL_WIDTH-1:0];
      res = mode_i ? {PIXEL_WIDTH{mag >= {4'b0000, threshold_i}}} : sat;
   end

   // line buffers are column-addressed: lb1 holds row r-1, lb2 holds row r-2
   always_ff @(posedge clk_i) begin
      if (acc) begin
         lb2[col_e] <= lb1[col_e];
         lb1[col_e] <= px_i;
         for (int i = 0; i < 9; i++)
            w[i] <= nw[i];
      end
   end

   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         state        <= IDLE;
         col          <= '0;
         row          <= '0;
         px_valid_o   <= 1'b0;
         px_o         <= '0;
         frame_done_o <= 1'b0;
         busy_o       <= 1'b0;
      end else begin
         state        <= state_n;
         col          <= col_n;
         row          <= row_n;
         px_valid_o   <= emit;
         px_o         <= emit ? res : px_o;
         frame_done_o <= emit && last_col && last_row && st_eff == STREAM;
         busy_o       <= state_n != IDLE;
      end
   end
endmodule

// File: tb/tb_sobel_stream.sv
// tb_sobel_stream: scoreboard bench for sobel_stream with directed frames and hand-derived results.
module tb_sobel_stream;
   logic       clk = 1'b0;
   logic       nreset_i = 1'b0;
   logic       start_i = 1'b0;
   logic       px_valid_i = 1'b0;
   logic [7:0] px_i = '0;
   logic       mode_i = 1'b0;
   logic [7:0] threshold_i = '0;
   logic       px_valid_o, frame_done_o, busy_o;
   logic [7:0] px_o;
   int tests = 0;
   int fails = 0;
   int cyc = 0;
   typedef struct {logic [7:0] v; int c; bit d;} exp_t;
   exp_t q[$];

   sobel_stream #(.PIXEL_WIDTH(8), .IMG_WIDTH(8), .IMG_HEIGHT(8)) dut (
      .clk_i(clk), .nreset_i(nreset_i), .start_i(start_i), .px_valid_i(px_valid_i),
      .px_i(px_i), .mode_i(mode_i), .threshold_i(threshold_i), .px_valid_o(px_valid_o),
      .px_o(px_o), .frame_done_o(frame_done_o), .busy_o(busy_o));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string n, input int a, input int e);
      tests++;
      if (a != e) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, a, e, cyc);
      end
   endtask

   // frame kinds: 0 uniform 50, 1 column ramp 10*c, 2 row ramp 10*r, 3 step at col 4, 4 all zero
   function automatic logic [7:0] pix(input int k, input int r, input int c);
      case (k)
         0: return 8'd50;
         1: return 8'(10 * c);
         2: return 8'(10 * r);
         3: return (c >= 4) ? 8'd200 : 8'd0;
         default: return 8'd0;
      endcase
   endfunction

   // hand-derived: ramps give 80, step gives 800 (saturates) at centre columns 3 and 4
   function automatic logic [7:0] expv(input int k, input int c, input bit m, input logic [7:0] t);
      int mg;
      mg = (k == 1 || k == 2) ? 80 : (k == 3 && (c - 1 == 3 || c - 1 == 4)) ? 800 : 0;
      if (m) return (mg >= int'(t)) ? 8'hff : 8'h00;
      return (mg > 255) ? 8'hff : 8'(mg);
   endfunction

   task automatic send_frame(input int k, input bit m, input logic [7:0] t, input int gap, input int stop);
      for (int r = 0; r < stop; r++)
         for (int c = 0; c < 8; c++) begin
            while (gap > 0 && $urandom_range(99) < gap) begin
               @(posedge clk); #1;
               px_valid_i = 1'b0;
               start_i = 1'b0;
            end
            @(posedge clk); #1;
            px_valid_i = 1'b1;
            start_i = (r == 0 && c == 0);
            px_i = pix(k, r, c);
            mode_i = m;
            threshold_i = t;
            if (r >= 2 && c >= 2) q.push_back('{expv(k, c, m, t), cyc + 1, (r == 7 && c == 7)});
         end
      @(posedge clk); #1;
      px_valid_i = 1'b0;
      start_i = 1'b0;
      if (stop == 8) chk("busy_after_frame", busy_o, 0);
   endtask

   always @(negedge clk) begin
      if (nreset_i) begin
         if (px_valid_o) begin
            if (q.size() == 0) begin
               chk("unexpected_output", 1, 0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("px_o", px_o, e.v);
               chk("out_cycle", cyc, e.c);
               chk("frame_done", frame_done_o, e.d);
            end
         end else if (frame_done_o) begin
            chk("done_without_valid", 1, 0);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      #12;
      chk("rst_valid", px_valid_o, 0);
      chk("rst_px", px_o, 0);
      chk("rst_done", frame_done_o, 0);
      chk("rst_busy", busy_o, 0);
      @(negedge clk);
      nreset_i = 1'b1;
      send_frame(0, 0, 8'd0, 0, 8);
      send_frame(1, 0, 8'd0, 0, 8);
      send_frame(2, 0, 8'd0, 0, 8);
      send_frame(3, 0, 8'd0, 0, 8);
      send_frame(1, 1, 8'd80, 0, 8);
      send_frame(1, 1, 8'd81, 0, 8);
      send_frame(1, 0, 8'd0, 50, 8);
      // valid without start in IDLE must produce nothing
      repeat (4) begin
         @(posedge clk); #1;
         px_valid_i = 1'b1;
         px_i = 8'd99;
      end
      @(posedge clk); #1;
      px_valid_i = 1'b0;
      chk("idle_busy", busy_o, 0);
      // restart mid-frame at row 4, then a full zero frame
      send_frame(1, 0, 8'd0, 0, 4);
      send_frame(4, 0, 8'd0, 0, 8);
      // async reset mid-frame
      send_frame(1, 0, 8'd0, 0, 3);
      repeat (2) @(posedge clk);
      #1;
      chk("pre_rst_busy", busy_o, 1);
      chk("pre_rst_px", px_o, 80);
      #2 nreset_i = 1'b0;
      #1;
      chk("arst_px", px_o, 0);
      chk("arst_busy", busy_o, 0);
      chk("arst_valid", px_valid_o, 0);
      @(negedge clk);
      nreset_i = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         px_valid_i = 1'b1;
      end
      @(posedge clk); #1;
      px_valid_i = 1'b0;
      chk("post_rst_busy", busy_o, 0);
      send_frame(4, 0, 8'd0, 0, 8);
      repeat (5) @(posedge clk);
      #1;
      chk("sb_empty", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
